// File: rtl/cpu_checker_pro.sv
// cpu_checker_pro: streaming checker for CPU trace records, one ASCII char per clock.
// Recognises register writes "^t@pc: $g <= d#" and memory writes "^t@pc: *a <= d#".
// Optional statistics counters (line_cnt, err_cnt) are built when CHECKER_STATS_EN is defined.
module cpu_checker_pro #(
  parameter int          TIME_DIGITS = 4,
  parameter int          GRF_DIGITS  = 4,
  parameter int          GRF_NUM     = 32,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_6fff,
  parameter logic [31:0] DM_HI       = 32'h0000_2fff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code,
  output logic [31:0] rec_pc,
  output logic [31:0] rec_data
`ifdef CHECKER_STATS_EN
  ,
  output logic [15:0] line_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE, TIME, PC, PC_END, SP1, GRF, ADDR, SP2, ARROW, SP3, DATA, DONE
  } state_t;

  localparam logic [3:0]  TIME_MAX = 4'(TIME_DIGITS);
  localparam logic [3:0]  GRF_MAX  = 4'(GRF_DIGITS);
  localparam logic [16:0] GRF_LIM  = 17'(GRF_NUM);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [16:0] time_acc;
  logic [16:0] grf_acc;
  logic [31:0] pc_acc;
  logic [31:0] addr_acc;
  logic [31:0] data_acc;
  logic        is_mem;

  logic        is_dec, is_hex;
  logic [3:0]  nib;
  logic [16:0] time_mask;
  logic [3:0]  err;
  logic        unused_bits;

  // Character classification; nibble value for 0-9 and lowercase a-f
  assign is_dec      = (char >= "0") && (char <= "9");
  assign is_hex      = is_dec || ((char >= "a") && (char <= "f"));
  assign nib         = is_dec ? char[3:0] : char[3:0] + 4'd9;
  assign time_mask   = {2'b00, freq[15:1] - 15'd1};
  assign unused_bits = freq[0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; '^' always restarts, anything unexpected falls back to IDLE
  always_comb begin
    next_state = IDLE;
    if (char == "^") begin
      next_state = TIME;
    end else begin
      case (state)
        TIME: begin
          if (is_dec && cnt < TIME_MAX)        next_state = TIME;
          else if (char == "@" && cnt != 4'd0) next_state = PC;
        end
        PC:     if (is_hex) next_state = (cnt == 4'd7) ? PC_END : PC;
        PC_END: if (char == ":") next_state = SP1;
        SP1: begin
          if (char == " ")      next_state = SP1;
          else if (char == "$") next_state = GRF;
          else if (char == "*") next_state = ADDR;
        end
        GRF: begin
          if (is_dec && cnt < GRF_MAX)         next_state = GRF;
          else if (char == " " && cnt != 4'd0) next_state = SP2;
          else if (char == "<" && cnt != 4'd0) next_state = ARROW;
        end
        ADDR: begin
          if (is_hex && cnt < 4'd8)            next_state = ADDR;
          else if (char == " " && cnt == 4'd8) next_state = SP2;
          else if (char == "<" && cnt == 4'd8) next_state = ARROW;
        end
        SP2: begin
          if (char == " ")      next_state = SP2;
          else if (char == "<") next_state = ARROW;
        end
        ARROW: if (char == "=") next_state = SP3;
        SP3: begin
          if (char == " ")  next_state = SP3;
          else if (is_hex)  next_state = DATA;
        end
        DATA: begin
          if (is_hex && cnt < 4'd8)            next_state = DATA;
          else if (char == "#" && cnt == 4'd8) next_state = DONE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Field accumulators and digit counter; a restart wipes everything
  always_ff @(posedge clk) begin
    if (reset || char == "^") begin
      cnt      <= 4'd0;
      time_acc <= 17'd0;
      grf_acc  <= 17'd0;
      pc_acc   <= 32'd0;
      addr_acc <= 32'd0;
      data_acc <= 32'd0;
      is_mem   <= 1'b0;
    end else begin
      case (state)
        TIME: begin
          if (next_state == TIME) begin
            time_acc <= 17'(time_acc * 17'd10 + {13'd0, nib});
            cnt      <= cnt + 4'd1;
          end else if (next_state == PC) begin
            cnt <= 4'd0;
          end
        end
        PC: begin
          if (next_state == PC || next_state == PC_END) begin
            pc_acc <= {pc_acc[27:0], nib};
            cnt    <= cnt + 4'd1;
          end
        end
        SP1: begin
          if (next_state == GRF) begin
            cnt    <= 4'd0;
            is_mem <= 1'b0;
          end else if (next_state == ADDR) begin
            cnt    <= 4'd0;
            is_mem <= 1'b1;
          end
        end
        GRF: begin
          if (next_state == GRF) begin
            grf_acc <= 17'(grf_acc * 17'd10 + {13'd0, nib});
            cnt     <= cnt + 4'd1;
          end
        end
        ADDR: begin
          if (next_state == ADDR) begin
            addr_acc <= {addr_acc[27:0], nib};
            cnt      <= cnt + 4'd1;
          end
        end
        SP3: begin
          if (next_state == DATA) begin
            data_acc <= {28'd0, nib};
            cnt      <= 4'd1;
          end
        end
        DATA: begin
          if (next_state == DATA) begin
            data_acc <= {data_acc[27:0], nib};
            cnt      <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Semantic error flags derived from the held accumulators
  always_comb begin
    err    = 4'd0;
    err[0] = |(time_acc & time_mask);
    err[1] = (pc_acc[1:0] != 2'd0) || (pc_acc < PC_LO) || (pc_acc > PC_HI);
    err[2] = is_mem && ((addr_acc[1:0] != 2'd0) || (addr_acc > DM_HI));
    err[3] = !is_mem && (grf_acc >= GRF_LIM);
  end

  // Output decode: only the DONE state exposes a result, everything else reads zero
  always_comb begin
    format_type = 2'b00;
    error_code  = 4'd0;
    rec_pc      = 32'd0;
    rec_data    = 32'd0;
    if (state == DONE) begin
      format_type = is_mem ? 2'b10 : 2'b01;
      error_code  = err;
      rec_pc      = pc_acc;
      rec_data    = data_acc;
    end
  end

`ifdef CHECKER_STATS_EN
  // Saturating record and error counters, bumped once per DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt <= 16'd0;
      err_cnt  <= 16'd0;
    end else if (state == DONE) begin
      if (line_cnt != 16'hffff)                     line_cnt <= line_cnt + 16'd1;
      if (error_code != 4'd0 && err_cnt != 16'hffff) err_cnt  <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_checker_pro.sv
// tb_cpu_checker_pro: directed bench for cpu_checker_pro with a scoreboard of expected records.
// Honours CHECKER_STATS_EN to hook up and check the statistics counters.
module tb_cpu_checker_pro;

  logic        clk;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic [31:0] rec_pc;
  logic [31:0] rec_data;
`ifdef CHECKER_STATS_EN
  logic [15:0] line_cnt;
  logic [15:0] err_cnt;
`endif

  typedef struct packed {
    logic [1:0]  fmt;
    logic [3:0]  err;
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  bit   mon_en       = 1'b0;

  cpu_checker_pro dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code),
    .rec_pc      (rec_pc),
    .rec_data    (rec_data)
`ifdef CHECKER_STATS_EN
    ,
    .line_cnt    (line_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report observed/expected on a miss
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a string one character per clock, then park the input on NUL
  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) begin
      char = s[i];
      @(posedge clk);
      #1;
    end
    char = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectRecord(input logic [1:0] fmt, input logic [3:0] err,
                              input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.fmt  = fmt;
    e.err  = err;
    e.pc   = pc;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor on the falling edge: every nonzero format must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (format_type !== 2'b00) begin
        n_compared++;
        assert (sb_q.size() != 0) else begin
          n_mismatched++;
          $error("[TB] FAIL unexpected_record: observed fmt %b pc %h expected none", format_type, rec_pc);
        end
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("format_type", 32'(format_type), 32'(e.fmt));
          checkOutput("error_code",  32'(error_code),  32'(e.err));
          checkOutput("rec_pc",      rec_pc,           e.pc);
          checkOutput("rec_data",    rec_data,         e.data);
        end
      end else begin
        checkOutput("idle_zero", {28'd0, error_code} | rec_pc | rec_data, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    char  = 8'h00;
    freq  = 16'd4;
    idle(2);
    @(negedge clk);
    checkOutput("reset_format", 32'(format_type), 32'd0);
    checkOutput("reset_error",  32'(error_code),  32'd0);
    checkOutput("reset_pc",     rec_pc,           32'd0);
    checkOutput("reset_data",   rec_data,         32'd0);
`ifdef CHECKER_STATS_EN
    checkOutput("reset_line_cnt", 32'(line_cnt), 32'd0);
    checkOutput("reset_err_cnt",  32'(err_cnt),  32'd0);
`endif
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    $display("[TB] reset released");

    // Plain register record, no errors
    expectRecord(2'b01, 4'b0000, 32'h0000_3010, 32'h0000_000a);
    applyStimulus("^10@00003010: $1 <= 0000000a#");
    idle(2);

    // Memory record: odd time, unaligned pc, addr above data memory
    expectRecord(2'b10, 4'b0111, 32'h0000_3012, 32'h1234_5678);
    applyStimulus("^7@00003012:*00003000<=12345678#");
    idle(2);

    // Restart inside the time field; grf out of range
    expectRecord(2'b01, 4'b1000, 32'h0000_3000, 32'h0000_0000);
    applyStimulus("^12^10@00003000:$40 <=00000000#");
    idle(2);

    // Too many time digits and a 9-digit pc must both be dropped silently
    applyStimulus("^12345@00003000:$1<=00000000#");
    idle(2);
    applyStimulus("^1@000030000:$1<=00000000#");
    idle(2);

    // freq=8: time must be a multiple of 4
    freq = 16'd8;
    expectRecord(2'b10, 4'b0001, 32'h0000_3ffc, 32'hdead_beef);
    applyStimulus("^6@00003ffc: *00002ffc <= deadbeef#");
    idle(2);
    expectRecord(2'b01, 4'b0000, 32'h0000_6ffc, 32'hffff_ffff);
    applyStimulus("^8@00006ffc:$31 <= ffffffff#");
    idle(2);
    freq = 16'd4;

    // Reset on the '<' aborts the record
    applyStimulus("^10@00003010: $1 ");
    reset = 1'b1;
    char  = "<";
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus("= 0000000a#");
    idle(2);
`ifdef CHECKER_STATS_EN
    checkOutput("abort_line_cnt", 32'(line_cnt), 32'd0);
    checkOutput("abort_err_cnt",  32'(err_cnt),  32'd0);
`endif

    // Back-to-back records, the second with a pc below the legal range
    expectRecord(2'b01, 4'b0000, 32'h0000_3010, 32'h0000_000a);
    expectRecord(2'b01, 4'b0010, 32'h0000_2ffc, 32'h0000_0001);
    applyStimulus("^10@00003010:$1<=0000000a#^10@00002ffc:$2<=00000001#");
    idle(3);
`ifdef CHECKER_STATS_EN
    checkOutput("b2b_line_cnt", 32'(line_cnt), 32'd2);
    checkOutput("b2b_err_cnt",  32'(err_cnt),  32'd1);
`endif

    // Every expected record must have been seen
    idle(4);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
